rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Shares the single register-file write port (`wd3`/`wa3`/`we3`) between two writeback sources: ALU result (requester A) and load/immediate path (requester B). Accepts per-requester valid/ready writes, picks one per cycle round-robin, and drives a registered write request into the 8×8-bit register file one cycle later. Drops writes to r0 and to out-of-range addresses, flags the latter, and counts committed writes for debug.

## Interface
Parameters:
- `NREG`, 8: register-file depth; addresses ≥ NREG are illegal.
- `DW`, 8: data width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `a_valid` in 1: requester A has a write pending.
- `a_addr` in 5: requester A destination register.
- `a_data` in DW: requester A write data.
- `a_ready` out 1: A's request accepted this cycle.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same for requester B.
- `flush` in 1: synchronous; discards the output stage and blocks acceptance this cycle.
- `wd3` out DW: write data to register file.
- `wa3` out 5: write address to register file.
- `we3` out 1: write enable to register file.
- `err_addr` out 1: sticky; set when an accepted write had address ≥ NREG.
- `wr_count` out 8: count of writes committed (`we3` high), wraps 255→0.

## Operation
- State: `last` (1 bit, 0=A last served, 1=B), output register {`wd3`,`wa3`,`we3`}, `err_addr`, `wr_count`.
- Grant (combinational, same cycle): `flush`=1 → no grant. Else only A valid → A; only B valid → B; both → the one not equal to `last`. Neither → no grant.
- `a_ready` = grant A; `b_ready` = grant B; never both high. Ready depends on valid; requesters must hold valid/addr/data stable until ready.
- On a grant: `last` ← granted requester; output register loads {data, addr}; `we3` ← 1 only if addr ≠ 0 and addr < NREG, else 0.
- Accepted addr ≥ NREG: `we3`=0, `err_addr` ← 1 (cleared only by reset).
- Accepted addr = 0: `we3`=0, no error (r0 hard-wired zero).
- No grant: `we3` ← 0; `wd3`/`wa3` hold previous values.
- `flush`=1: `we3` ← 0 next edge regardless of valids; `last` unchanged.
- `wr_count` increments on each edge where registered `we3` is 1 (counts the write the register file actually performs).

## Timing
- Reset (`rst`=0, async): `wd3`=0, `wa3`=0, `we3`=0, `err_addr`=0, `wr_count`=0, `last`=1 (A wins first tie). `a_ready`/`b_ready` forced 0 while in reset.
- Latency: request accepted at edge N (valid&ready) → `we3`/`wa3`/`wd3` valid after edge N → register file stores at edge N+1; readable via `rd1`/`rd2` after N+1.
- Throughput: one write per cycle; with both valid continuously, grants alternate A,B,A,B…
- Reset deasserted mid-stream: first grant after release follows tie rule from `last`=1.
- Reset asserted while `we3`=1: `we3` drops immediately (async); pending write lost.
- Flush and grant conflict: flush wins, no ready asserted.

## Configuration
- `RFARB_FIXED_PRIO_EN`: defined → A always wins ties (fixed priority, `last` ignored for arbitration but still updated). Undefined → round-robin as above.

## Test plan
- Reset: hold `rst`=0, drive valids → both ready 0, `we3`=0, `wr_count`=0, `err_addr`=0.
- Single write: A valid, addr 3, data 0x5A → `a_ready`=1 that cycle; next cycle `we3`=1, `wa3`=3, `wd3`=0x5A; `wr_count`=1 one edge later.
- Tie round-robin: A(addr 1, 0x11) and B(addr 2, 0x22) held valid 4 cycles → grants A,B,A,B; `we3` high 4 consecutive cycles; `wr_count`=4. With `RFARB_FIXED_PRIO_EN`: grants A,A,A,A, B never ready.
- Address filtering: A writes addr 0 then addr 9 → both accepted, `we3`=0 both times, `err_addr`=1 after addr 9, `wr_count` unchanged.
- Flush: A valid addr 4 with `flush`=1 → `a_ready`=0, `we3`=0; flush released → accepted next cycle.
- Async reset mid-write: `rst` pulsed low between edges while `we3`=1 → `we3`, `wr_count` immediately 0; after release A wins first tie.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load/imm (B) paths.
// Define RFARB_FIXED_PRIO_EN to make A win every tie (fixed priority) instead of alternating.
module rf_write_arbiter #(
  parameter int NREG = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [4:0]    a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [4:0]    b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          flush,
  output logic [DW-1:0] wd3,
  output logic [4:0]    wa3,
  output logic          we3,
  output logic          err_addr,
  output logic [7:0]    wr_count
);

  localparam logic [5:0] NREG_LIM = 6'(NREG);

  logic          last;
  logic          grant_a;
  logic          grant_b;
  logic          grant_any;
  logic [4:0]    sel_addr;
  logic [DW-1:0] sel_data;
  logic          addr_in_range;
  logic          addr_nonzero;

  // Flush blocks every grant; a tie goes to whichever requester was not served last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!flush) begin
      if (a_valid && b_valid) begin
`ifdef RFARB_FIXED_PRIO_EN
        grant_a = 1'b1;
`else
        grant_a = last;
        grant_b = !last;
`endif
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign grant_any = grant_a | grant_b;
  assign a_ready   = grant_a & rst;
  assign b_ready   = grant_b & rst;

  assign sel_addr      = grant_b ? b_addr : a_addr;
  assign sel_data      = grant_b ? b_data : a_data;
  assign addr_in_range = {1'b0, sel_addr} < NREG_LIM;
  assign addr_nonzero  = |sel_addr;

  // Output stage: r0 and out-of-range targets are accepted but never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last     <= 1'b1;
      wd3      <= '0;
      wa3      <= '0;
      we3      <= 1'b0;
      err_addr <= 1'b0;
    end else if (grant_any) begin
      last <= grant_b;
      wd3  <= sel_data;
      wa3  <= sel_addr;
      we3  <= addr_in_range && addr_nonzero;
      if (!addr_in_range) begin
        err_addr <= 1'b1;
      end
    end else begin
      we3 <= 1'b0;
    end
  end

  // Counts the write the register file performs on this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (we3) begin
      wr_count <= wr_count + 8'd1;
    end
  end

endmodule
